copro_fifo_ctrl: RTL and testbench
==================================

// Module: copro_fifo_ctrl
// PURPOSE
//  Coprocessor-side controller for the two 8-bit CPC<->copro link FIFO chips: the other end of the
//  host IO-port interface. Drains the host->copro FIFO output (DOR/SO) into a valid/ready byte stream.
//  Fills the copro->host FIFO input (DIR/SI) from a second valid/ready stream.
//  Sits between the FIFO ICs and the copro bus logic; all FIFO flags are asynchronous and synchronised here.
// PARAMETERS
//  SYNC_STAGES     2  flip-flops per flag synchroniser (>=2)
//  STROBE_CYCLES   2  high width of SI/SO pulses, clk cycles (>=1)
//  RECOVER_CYCLES  3  cycles after strobe before flag re-sampled; must be >= SYNC_STAGES+1
//  CNT_W          16  width of byte counters
// PORTS
//  clk            in   1  copro-side clock
//  reset          in   1  asynchronous, active-high reset
//  fifo_copro_dor in   1  host->copro FIFO data-out-ready (async)
//  fifo_copro_q   in   8  host->copro FIFO output data (valid while DOR high)
//  o_fifo_so      out  1  host->copro FIFO shift-out strobe, active high
//  fifo_copro_dir in   1  copro->host FIFO data-in-ready (async)
//  o_fifo_d       out  8  copro->host FIFO input data
//  o_fifo_si      out  1  copro->host FIFO shift-in strobe, active high
//  rx_data        out  8  received byte
//  rx_valid       out  1  rx_data holds an unconsumed byte
//  rx_ready       in   1  consumer accepts rx_data when rx_valid&&rx_ready
//  tx_data        in   8  byte to send
//  tx_valid       in   1  tx_data valid
//  tx_ready       out  1  byte accepted when tx_valid&&tx_ready
//  rx_count       out  CNT_W  bytes delivered on rx stream, wraps modulo 2^CNT_W
//  tx_count       out  CNT_W  bytes strobed into FIFO, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (async assert, sync to clk on release): all outputs 0, both FSMs IDLE, synchronisers cleared (flags read 0).
//  Flags: dor_s/dir_s = SYNC_STAGES-deep synchronised copies; raw flags never used in logic.
//  RX FSM  R_IDLE -> R_STROBE -> R_RECOV -> R_IDLE
//   R_IDLE: if dor_s && (!rx_valid || rx_ready): rx_data<=fifo_copro_q, rx_valid<=1, go R_STROBE.
//     Capture and consume in same cycle allowed (back-to-back; rx_valid stays 1).
//   R_STROBE: o_fifo_so=1 for exactly STROBE_CYCLES cycles. R_RECOV: so=0 for RECOVER_CYCLES, then R_IDLE.
//   rx_valid clears on rx_valid&&rx_ready with no same-cycle capture; rx_data stable while rx_valid&&!rx_ready.
//   rx_count increments on each rx handshake. Min per-byte period = 1+STROBE+RECOVER cycles (6 default).
//   Latency: DOR rise -> rx_valid = SYNC_STAGES+1 cycles.
//  TX FSM  T_IDLE -> T_SETUP -> T_STROBE -> T_HOLD -> T_RECOV -> T_IDLE
//   tx_ready = (state==T_IDLE) && dir_s (combinational from registers only, not from tx_valid).
//   Accept: o_fifo_d<=tx_data; T_SETUP 1 cycle (data setup), T_STROBE si=1 for STROBE_CYCLES,
//   T_HOLD 1 cycle si=0 data held, T_RECOV RECOVER_CYCLES; then T_IDLE. o_fifo_d keeps last value after.
//   tx_count increments on entry to T_HOLD.
//  Boundaries: FIFO empty (dor_s=0) -> RX stays IDLE, no SO; FIFO full (dir_s=0) -> tx_ready=0.
//   Flag drop during STROBE/RECOV ignored; strobe always completes full width (no runt pulses).
//   RX and TX FSMs independent; simultaneous activity permitted.
//   Reset mid-strobe: SI/SO drop immediately (async); byte in flight is lost, counters cleared.
//   Counters wrap 2^CNT_W-1 -> 0 silently.
//   Host-side FIFO reset while DOR high: flag falls; RX completes any strobe in progress, then idles.
// STRUCTURE
//  cplink_defs.vh: RX/TX state encodings, default STROBE/RECOVER constants, shared with host-side block.
//  One sub-module: cplink_flag_sync (parameterised SYNC_STAGES, async-reset shift register), instanced twice.
//  RX FSM, TX FSM, counters in this module; elaboration check RECOVER_CYCLES>=SYNC_STAGES+1.
// TESTING
//  1 Reset held, flags=1 -> so=si=0, rx_valid=0, tx_ready=0, counts=0; release -> tx_ready=1 after 2 cycles.
//  2 FIFO model holds 0xA5,0x3C, rx_ready=1 -> rx stream 0xA5 then 0x3C, exactly two 2-cycle SO pulses, rx_count=2.
//  3 rx_ready=0 with 3 bytes queued -> one SO only, rx_data=first byte stable; release rx_ready -> remaining two delivered.
//  4 tx_valid=1 with 0x55,0xAA, dir=1 -> o_fifo_d stable 1 cycle before/after each 2-cycle SI; tx_count=2.
//  5 FIFO model full (dir=0) -> tx_ready=0, no SI; dir rises -> byte strobed 2+1 cycles later.
//  6 Assert reset during SO pulse -> so=0 same cycle, rx_valid=0; normal traffic resumes after release.

Source files
------------

// File: rtl/copro_fifo_ctrl_pkg.sv
// rtl/copro_fifo_ctrl_pkg.sv - shared state encodings and default timing for the copro FIFO link
package copro_fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    R_IDLE,
    R_STROBE,
    R_RECOV
  } rx_state_e;

  typedef enum logic [2:0] {
    T_IDLE,
    T_SETUP,
    T_STROBE,
    T_HOLD,
    T_RECOV
  } tx_state_e;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_STROBE_CYCLES  = 2;
  localparam int DEF_RECOVER_CYCLES = 3;
  localparam int DEF_CNT_W          = 16;
  localparam int TIMER_W            = 8;

endpackage

// File: rtl/copro_fifo_ctrl_if.sv
// rtl/copro_fifo_ctrl_if.sv - FIFO pins plus rx/tx byte streams of the copro link controller
interface copro_fifo_ctrl_if
  import copro_fifo_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic             fifo_copro_dor;
  logic [7:0]       fifo_copro_q;
  logic             o_fifo_so;
  logic             fifo_copro_dir;
  logic [7:0]       o_fifo_d;
  logic             o_fifo_si;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [CNT_W-1:0] rx_count;
  logic [CNT_W-1:0] tx_count;

  modport slave (
    input  fifo_copro_dor, fifo_copro_q, fifo_copro_dir, rx_ready, tx_data, tx_valid,
    output o_fifo_so, o_fifo_d, o_fifo_si, rx_data, rx_valid, tx_ready, rx_count, tx_count
  );

  modport master (
    output fifo_copro_dor, fifo_copro_q, fifo_copro_dir, rx_ready, tx_data, tx_valid,
    input  o_fifo_so, o_fifo_d, o_fifo_si, rx_data, rx_valid, tx_ready, rx_count, tx_count
  );
endinterface

// File: rtl/copro_fifo_ctrl_flag_sync.sv
// rtl/copro_fifo_ctrl_flag_sync.sv - multi-stage synchroniser for an asynchronous FIFO flag
module copro_fifo_ctrl_flag_sync
  import copro_fifo_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic flag_i,
  output logic flag_o
);
  logic [SYNC_STAGES-1:0] sync_q;

  if (SYNC_STAGES < 2) begin : g_stage_chk
    $error("SYNC_STAGES must be at least 2");
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], flag_i};
    end
  end

  assign flag_o = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/copro_fifo_ctrl.sv
// rtl/copro_fifo_ctrl.sv - drains host->copro FIFO into rx stream, fills copro->host FIFO from tx stream
module copro_fifo_ctrl
  import copro_fifo_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int STROBE_CYCLES  = DEF_STROBE_CYCLES,
  parameter int RECOVER_CYCLES = DEF_RECOVER_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input logic               clk,
  input logic               reset,
  copro_fifo_ctrl_if.slave  bus
);
  if (RECOVER_CYCLES < SYNC_STAGES + 1) begin : g_recover_chk
    $error("RECOVER_CYCLES must cover the flag synchroniser delay");
  end
  if (STROBE_CYCLES < 1) begin : g_strobe_chk
    $error("STROBE_CYCLES must be at least 1");
  end

  logic dor_s, dir_s;

  copro_fifo_ctrl_flag_sync #(.SYNC_STAGES(SYNC_STAGES)) u_dor_sync (
    .clk(clk), .rst(reset), .flag_i(bus.fifo_copro_dor), .flag_o(dor_s)
  );
  copro_fifo_ctrl_flag_sync #(.SYNC_STAGES(SYNC_STAGES)) u_dir_sync (
    .clk(clk), .rst(reset), .flag_i(bus.fifo_copro_dir), .flag_o(dir_s)
  );

  rx_state_e          rx_state_q, rx_state_d;
  logic [TIMER_W-1:0] rx_tmr_q, rx_tmr_d;
  logic [7:0]         rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic [CNT_W-1:0]   rx_count_q, rx_count_d;

  tx_state_e          tx_state_q, tx_state_d;
  logic [TIMER_W-1:0] tx_tmr_q, tx_tmr_d;
  logic [7:0]         tx_d_q, tx_d_d;
  logic [CNT_W-1:0]   tx_count_q, tx_count_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q <= R_IDLE;
      rx_tmr_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_count_q <= '0;
      tx_state_q <= T_IDLE;
      tx_tmr_q   <= '0;
      tx_d_q     <= '0;
      tx_count_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_tmr_q   <= rx_tmr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_count_q <= rx_count_d;
      tx_state_q <= tx_state_d;
      tx_tmr_q   <= tx_tmr_d;
      tx_d_q     <= tx_d_d;
      tx_count_q <= tx_count_d;
    end
  end

  // A consumed byte may be replaced in the same cycle, keeping rx_valid high back-to-back.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tmr_d   = rx_tmr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_count_d = rx_count_q;
    if (rx_valid_q && bus.rx_ready) begin
      rx_valid_d = 1'b0;
      rx_count_d = rx_count_q + CNT_W'(1);
    end
    case (rx_state_q)
      R_IDLE: begin
        if (dor_s && (!rx_valid_q || bus.rx_ready)) begin
          rx_data_d  = bus.fifo_copro_q;
          rx_valid_d = 1'b1;
          rx_tmr_d   = '0;
          rx_state_d = R_STROBE;
        end
      end
      R_STROBE: begin
        if (rx_tmr_q == TIMER_W'(STROBE_CYCLES - 1)) begin
          rx_tmr_d   = '0;
          rx_state_d = R_RECOV;
        end else begin
          rx_tmr_d = rx_tmr_q + TIMER_W'(1);
        end
      end
      R_RECOV: begin
        if (rx_tmr_q == TIMER_W'(RECOVER_CYCLES - 1)) begin
          rx_tmr_d   = '0;
          rx_state_d = R_IDLE;
        end else begin
          rx_tmr_d = rx_tmr_q + TIMER_W'(1);
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tmr_d   = tx_tmr_q;
    tx_d_d     = tx_d_q;
    tx_count_d = tx_count_q;
    case (tx_state_q)
      T_IDLE: begin
        if (dir_s && bus.tx_valid) begin
          tx_d_d     = bus.tx_data;
          tx_state_d = T_SETUP;
        end
      end
      T_SETUP: begin
        tx_tmr_d   = '0;
        tx_state_d = T_STROBE;
      end
      T_STROBE: begin
        if (tx_tmr_q == TIMER_W'(STROBE_CYCLES - 1)) begin
          tx_tmr_d   = '0;
          tx_count_d = tx_count_q + CNT_W'(1);
          tx_state_d = T_HOLD;
        end else begin
          tx_tmr_d = tx_tmr_q + TIMER_W'(1);
        end
      end
      T_HOLD: begin
        tx_tmr_d   = '0;
        tx_state_d = T_RECOV;
      end
      T_RECOV: begin
        if (tx_tmr_q == TIMER_W'(RECOVER_CYCLES - 1)) begin
          tx_tmr_d   = '0;
          tx_state_d = T_IDLE;
        end else begin
          tx_tmr_d = tx_tmr_q + TIMER_W'(1);
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign bus.o_fifo_so = (rx_state_q == R_STROBE);
  assign bus.o_fifo_si = (tx_state_q == T_STROBE);
  assign bus.o_fifo_d  = tx_d_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.tx_ready  = (tx_state_q == T_IDLE) && dir_s;
  assign bus.rx_count  = rx_count_q;
  assign bus.tx_count  = tx_count_q;
endmodule

// File: tb/tb_copro_fifo_ctrl.sv
// tb/tb_copro_fifo_ctrl.sv - directed bench for copro_fifo_ctrl with simple FIFO chip models
module tb_copro_fifo_ctrl;
  import copro_fifo_ctrl_pkg::*;

  localparam int CNT_W  = 16;
  localparam int STROBE = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  copro_fifo_ctrl_if #(.CNT_W(CNT_W)) bus ();

  copro_fifo_ctrl #(
    .SYNC_STAGES(2), .STROBE_CYCLES(STROBE), .RECOVER_CYCLES(3), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] h2c_q[$];
  logic [7:0] c2h_q[$];
  logic [7:0] rx_got[$];
  int so_pulses = 0, si_pulses = 0, so_len = 0, si_len = 0;
  logic so_prev = 1'b0, si_prev = 1'b0;
  logic [7:0] d_prev = 8'h00, si_d = 8'h00;
  bit found;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] got_at(input int i);
    return (i < rx_got.size()) ? rx_got[i] : 8'hEE;
  endfunction

  function automatic logic [7:0] c2h_at(input int i);
    return (i < c2h_q.size()) ? c2h_q[i] : 8'hEE;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic at_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    at_drive();
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.tx_ready) ok = 1'b1;
    end
    check_eq("tx_accept", 32'(ok), 32'd1);
    at_drive();
    bus.tx_valid = 1'b0;
  endtask

  // FIFO chip models and rx consumer, all sampled on the falling edge.
  initial begin
    bus.fifo_copro_dor = 1'b0;
    bus.fifo_copro_q   = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        so_prev = 1'b0; si_prev = 1'b0; so_len = 0; si_len = 0;
      end else begin
        if (bus.o_fifo_so) begin
          if (!so_prev) begin
            so_pulses++;
            if (h2c_q.size() > 0) void'(h2c_q.pop_front());
          end
          so_len++;
        end else if (so_prev) begin
          check_eq("so_width", 32'(so_len), 32'(STROBE));
          so_len = 0;
        end
        so_prev = bus.o_fifo_so;
        if (bus.o_fifo_si) begin
          if (!si_prev) begin
            si_pulses++;
            check_eq("si_setup", 32'(bus.o_fifo_d), 32'(d_prev));
            si_d = bus.o_fifo_d;
            c2h_q.push_back(bus.o_fifo_d);
          end
          si_len++;
        end else if (si_prev) begin
          check_eq("si_width", 32'(si_len), 32'(STROBE));
          check_eq("si_hold", 32'(bus.o_fifo_d), 32'(si_d));
          si_len = 0;
        end
        si_prev = bus.o_fifo_si;
        if (bus.rx_valid && bus.rx_ready) rx_got.push_back(bus.rx_data);
      end
      bus.fifo_copro_dor = (h2c_q.size() > 0);
      bus.fifo_copro_q   = (h2c_q.size() > 0) ? h2c_q[0] : 8'h00;
      d_prev = bus.o_fifo_d;
    end
  end

  initial begin
    bus.fifo_copro_dir = 1'b1;
    bus.rx_ready = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    h2c_q.push_back(8'hA5);
    h2c_q.push_back(8'h3C);

    // reset held with both flags high
    cycles(3);
    check_eq("rst_so", 32'(bus.o_fifo_so), 32'd0);
    check_eq("rst_si", 32'(bus.o_fifo_si), 32'd0);
    check_eq("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check_eq("rst_tx_ready", 32'(bus.tx_ready), 32'd0);
    check_eq("rst_rx_count", 32'(bus.rx_count), 32'd0);
    check_eq("rst_tx_count", 32'(bus.tx_count), 32'd0);
    at_drive();
    reset = 1'b0;
    cycles(2);
    check_eq("tx_ready_1clk", 32'(bus.tx_ready), 32'd0);
    cycles(1);
    check_eq("tx_ready_2clk", 32'(bus.tx_ready), 32'd1);
    check_eq("rx_valid_2clk", 32'(bus.rx_valid), 32'd0);
    cycles(1);
    check_eq("rx_valid_3clk", 32'(bus.rx_valid), 32'd1);
    check_eq("rx_data_first", 32'(bus.rx_data), 32'hA5);
    check_eq("so_first", 32'(bus.o_fifo_so), 32'd1);

    // two bytes drained, then FIFO empty
    cycles(20);
    check_eq("rx2_n", 32'(rx_got.size()), 32'd2);
    check_eq("rx2_b0", 32'(got_at(0)), 32'hA5);
    check_eq("rx2_b1", 32'(got_at(1)), 32'h3C);
    check_eq("rx2_so_pulses", 32'(so_pulses), 32'd2);
    check_eq("rx2_count", 32'(bus.rx_count), 32'd2);

    // backpressure with three bytes queued
    at_drive();
    bus.rx_ready = 1'b0;
    rx_got.delete();
    so_pulses = 0;
    h2c_q.push_back(8'h01);
    h2c_q.push_back(8'h02);
    h2c_q.push_back(8'h03);
    cycles(20);
    check_eq("bp_so_pulses", 32'(so_pulses), 32'd1);
    check_eq("bp_rx_valid", 32'(bus.rx_valid), 32'd1);
    check_eq("bp_rx_data", 32'(bus.rx_data), 32'h01);
    cycles(5);
    check_eq("bp_rx_stable", 32'(bus.rx_data), 32'h01);
    at_drive();
    bus.rx_ready = 1'b1;
    cycles(30);
    check_eq("bp_n", 32'(rx_got.size()), 32'd3);
    check_eq("bp_b0", 32'(got_at(0)), 32'h01);
    check_eq("bp_b1", 32'(got_at(1)), 32'h02);
    check_eq("bp_b2", 32'(got_at(2)), 32'h03);
    check_eq("bp_so_total", 32'(so_pulses), 32'd3);
    check_eq("bp_rx_count", 32'(bus.rx_count), 32'd5);

    // two bytes sent into a non-full FIFO
    send_byte(8'h55);
    send_byte(8'hAA);
    cycles(15);
    check_eq("tx_n", 32'(c2h_q.size()), 32'd2);
    check_eq("tx_b0", 32'(c2h_at(0)), 32'h55);
    check_eq("tx_b1", 32'(c2h_at(1)), 32'hAA);
    check_eq("tx_si_pulses", 32'(si_pulses), 32'd2);
    check_eq("tx_count", 32'(bus.tx_count), 32'd2);

    // FIFO full blocks tx until DIR rises
    at_drive();
    bus.fifo_copro_dir = 1'b0;
    cycles(4);
    check_eq("full_tx_ready", 32'(bus.tx_ready), 32'd0);
    at_drive();
    bus.tx_data  = 8'h77;
    bus.tx_valid = 1'b1;
    cycles(8);
    check_eq("full_no_si", 32'(si_pulses), 32'd2);
    check_eq("full_tx_ready2", 32'(bus.tx_ready), 32'd0);
    at_drive();
    bus.fifo_copro_dir = 1'b1;
    cycles(2);
    check_eq("dir_sync1", 32'(bus.tx_ready), 32'd0);
    cycles(1);
    check_eq("dir_sync2", 32'(bus.tx_ready), 32'd1);
    cycles(1);
    check_eq("dir_setup_si", 32'(bus.o_fifo_si), 32'd0);
    bus.tx_valid = 1'b0;
    cycles(1);
    check_eq("dir_strobe_si", 32'(bus.o_fifo_si), 32'd1);
    cycles(10);
    check_eq("full_tx_b", 32'(c2h_at(2)), 32'h77);
    check_eq("full_tx_count", 32'(bus.tx_count), 32'd3);

    // reset in the middle of an SO pulse
    at_drive();
    bus.rx_ready = 1'b0;
    rx_got.delete();
    so_pulses = 0;
    h2c_q.push_back(8'h11);
    h2c_q.push_back(8'h22);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (bus.o_fifo_so) found = 1'b1;
    end
    check_eq("mid_so_seen", 32'(found), 32'd1);
    #1 reset = 1'b1;
    #1;
    check_eq("mid_rst_so", 32'(bus.o_fifo_so), 32'd0);
    check_eq("mid_rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check_eq("mid_rst_rx_count", 32'(bus.rx_count), 32'd0);
    check_eq("mid_rst_tx_count", 32'(bus.tx_count), 32'd0);
    cycles(2);
    at_drive();
    reset = 1'b0;
    bus.rx_ready = 1'b1;
    cycles(20);
    check_eq("resume_n", 32'(rx_got.size()), 32'd1);
    check_eq("resume_b0", 32'(got_at(0)), 32'h22);
    check_eq("resume_rx_count", 32'(bus.rx_count), 32'd1);
    check_eq("resume_so_pulses", 32'(so_pulses), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
